udp_tx_frame_builder: RTL and testbench

//  UDP transmit stage, directly upstream of the IP transmit layer. Accepts a user payload as a contiguous byte

---
 rtl/udp_pkg.sv | 43 ++++
 rtl/udp_tx_frame_builder_if.sv | 33 +++
 rtl/udp_tx_fifo.sv | 65 ++++++
 rtl/udp_tx_frame_builder.sv | 192 +++++++++++++++++++
 tb/tb_udp_tx_frame_builder.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkg.sv
// udp_pkg -- shared constants, FSM encoding and header helper for the UDP
// transmit path.
//   P_TYPE_UDP        IPv4 protocol number for UDP
//   UDP_HDR_LEN       UDP header size in bytes
//   DEFAULT_*_PORT    power-up source/destination ports
//   state_t           frame builder FSM states
//   udp_hdr_byte()    selects one of the eight header bytes by index
package udp_pkg;

  localparam logic [7:0]  P_TYPE_UDP       = 8'd17;
  localparam int          UDP_HDR_LEN      = 8;
  localparam logic [15:0] DEFAULT_SRC_PORT = 16'd8080;
  localparam logic [15:0] DEFAULT_DST_PORT = 16'd8080;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // Header layout: src port, dst port, length, checksum (all big-endian).
  // The checksum is always zero, meaning "not computed" for UDP over IPv4.
  function automatic logic [7:0] udp_hdr_byte(input logic [15:0] src,
                                              input logic [15:0] dst,
                                              input logic [15:0] len,
                                              input logic [2:0]  idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = src[15:8];
      3'd1:    b = src[7:0];
      3'd2:    b = dst[15:8];
      3'd3:    b = dst[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_tx_frame_builder_if.sv
// udp_tx_frame_builder_if -- byte streams around the UDP frame builder.
//   User side : i_user_data/i_user_last/i_user_valid in, o_user_ready out
//   IP side   : o_ip_data/o_ip_type/o_ip_len/o_ip_last/o_ip_valid out
// Modports:
//   master -- the surrounding logic (payload source and IP layer sink)
//   slave  -- the frame builder itself
interface udp_tx_frame_builder_if;
  import udp_pkg::*;

  logic [7:0]  i_user_data;
  logic        i_user_last;
  logic        i_user_valid;
  logic        o_user_ready;

  logic [7:0]  o_ip_data;
  logic [7:0]  o_ip_type;
  logic [15:0] o_ip_len;
  logic        o_ip_last;
  logic        o_ip_valid;

  modport master (
    output i_user_data, i_user_last, i_user_valid,
    input  o_user_ready,
    input  o_ip_data, o_ip_type, o_ip_len, o_ip_last, o_ip_valid
  );

  modport slave (
    input  i_user_data, i_user_last, i_user_valid,
    output o_user_ready,
    output o_ip_data, o_ip_type, o_ip_len, o_ip_last, o_ip_valid
  );

endinterface

// File: rtl/udp_tx_fifo.sv
// udp_tx_fifo -- synchronous byte FIFO used as the payload buffer.
//   i_clk      clock
//   i_srst     synchronous active-high flush
//   i_wr_en    write strobe (ignored when full)
//   i_wr_data  byte to write
//   i_rd_en    read strobe (ignored when empty)
//   o_rd_data  byte read, valid the cycle after i_rd_en
//   o_full     no free entries
//   o_empty    no stored entries
module udp_tx_fifo
  import udp_pkg::*;
#(
  parameter int P_DEPTH = 2048
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  output logic [7:0] o_rd_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(P_DEPTH);

  logic [7:0]  mem [P_DEPTH];
  logic [7:0]  rd_data_q;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        wr_ok, rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_ok   = i_wr_en && !o_full;
  assign rd_ok   = i_rd_en && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
    if (rd_ok) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/udp_tx_frame_builder.sv
// udp_tx_frame_builder -- UDP transmit stage feeding the IP transmit layer.
// Buffers a whole user payload, then emits the 8-byte UDP header followed by
// the payload as one contiguous byte stream.
//   i_clk             clock
//   i_rst             asynchronous active-high reset
//   i_src_port(_valid) load new UDP source port
//   i_dst_port(_valid) load new UDP destination port
//   bus (slave)       user payload stream in, IP byte stream out
module udp_tx_frame_builder
  import udp_pkg::*;
#(
  parameter logic [15:0] P_SRC_PORT   = DEFAULT_SRC_PORT,
  parameter logic [15:0] P_DST_PORT   = DEFAULT_DST_PORT,
  parameter int          P_MAX_LEN    = 1472,
  parameter int          P_FIFO_DEPTH = 2048,
  parameter int          P_GAP        = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [15:0]            i_src_port,
  input  logic                   i_src_port_valid,
  input  logic [15:0]            i_dst_port,
  input  logic                   i_dst_port_valid,
  udp_tx_frame_builder_if.slave  bus
);

  state_t      state_q, state_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [15:0] hdr_src_q, hdr_src_d;
  logic [15:0] hdr_dst_q, hdr_dst_d;
  logic [15:0] cnt_q, cnt_d;     // payload bytes kept for this frame
  logic [15:0] len_q, len_d;     // UDP length presented on o_ip_len
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [15:0] rem_q, rem_d;     // payload bytes still to emit
  logic [15:0] gap_q, gap_d;
  logic [7:0]  ip_data_q, ip_data_d;
  logic        ip_valid_q, ip_valid_d;
  logic        ip_last_q, ip_last_d;

  logic        enter_hdr;
  logic        fifo_wr_en, fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        fifo_full, fifo_empty;

  udp_tx_fifo #(
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_srst    (i_rst),
    .i_wr_en   (fifo_wr_en),
    .i_wr_data (bus.i_user_data),
    .i_rd_en   (fifo_rd_en),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    src_port_d = i_src_port_valid ? i_src_port : src_port_q;
    dst_port_d = i_dst_port_valid ? i_dst_port : dst_port_q;
    hdr_src_d  = hdr_src_q;
    hdr_dst_d  = hdr_dst_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hdr_idx_d  = hdr_idx_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    ip_data_d  = 8'h00;
    ip_valid_d = 1'b0;
    ip_last_d  = 1'b0;
    enter_hdr  = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_rd_en = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_user_valid) begin
          fifo_wr_en = !fifo_full;
          cnt_d      = 16'd1;
          if (bus.i_user_last) begin
            state_d   = S_HDR;
            enter_hdr = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (bus.i_user_valid) begin
          // Bytes past the maximum are accepted and thrown away.
          if (cnt_q < 16'(P_MAX_LEN)) begin
            fifo_wr_en = !fifo_full;
            cnt_d      = cnt_q + 16'd1;
          end
          if (bus.i_user_last) begin
            state_d   = S_HDR;
            enter_hdr = 1'b1;
          end
        end
      end

      // Output bytes are registered: the byte chosen here appears next cycle.
      S_HDR: begin
        ip_valid_d = 1'b1;
        ip_data_d  = udp_hdr_byte(hdr_src_q, hdr_dst_q, len_q, hdr_idx_q);
        hdr_idx_d  = hdr_idx_q + 3'd1;
        if (hdr_idx_q == 3'd7) begin
          // First payload read overlaps the last header byte so the FIFO
          // output is ready the cycle after, giving a bubble-free stream.
          fifo_rd_en = !fifo_empty;
          rem_d      = cnt_q;
          state_d    = S_DATA;
        end
      end

      S_DATA: begin
        ip_valid_d = 1'b1;
        ip_data_d  = fifo_rd_data;
        ip_last_d  = (rem_q == 16'd1);
        rem_d      = rem_q - 16'd1;
        if (rem_q > 16'd1) begin
          fifo_rd_en = !fifo_empty;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end

      S_GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == 16'(P_GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Freeze ports and length for the frame about to be sent, so later port
    // updates only affect the following frame.
    if (enter_hdr) begin
      hdr_src_d = src_port_q;
      hdr_dst_d = dst_port_q;
      len_d     = cnt_d + 16'(UDP_HDR_LEN);
      hdr_idx_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      src_port_q <= P_SRC_PORT;
      dst_port_q <= P_DST_PORT;
      hdr_src_q  <= P_SRC_PORT;
      hdr_dst_q  <= P_DST_PORT;
      cnt_q      <= '0;
      len_q      <= '0;
      hdr_idx_q  <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      ip_data_q  <= '0;
      ip_valid_q <= 1'b0;
      ip_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
      hdr_src_q  <= hdr_src_d;
      hdr_dst_q  <= hdr_dst_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hdr_idx_q  <= hdr_idx_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      ip_data_q  <= ip_data_d;
      ip_valid_q <= ip_valid_d;
      ip_last_q  <= ip_last_d;
    end
  end

  assign bus.o_user_ready = (state_q == S_IDLE);
  assign bus.o_ip_data    = ip_data_q;
  assign bus.o_ip_type    = P_TYPE_UDP;
  assign bus.o_ip_len     = len_q;
  assign bus.o_ip_last    = ip_last_q;
  assign bus.o_ip_valid   = ip_valid_q;

endmodule

// File: tb/tb_udp_tx_frame_builder.sv
// tb_udp_tx_frame_builder -- self-checking bench for udp_tx_frame_builder.
// Frames are built from a byte-queue model of the UDP frame format and
// compared byte for byte with what appears on the IP side.
module tb_udp_tx_frame_builder;

  localparam int MAX_LEN = 1472;
  localparam int GAP     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_port, dst_port;
  logic        src_v, dst_v;

  always #5 clk = ~clk;

  udp_tx_frame_builder_if bus();

  udp_tx_frame_builder #(
    .P_SRC_PORT   (16'd8080),
    .P_DST_PORT   (16'd8080),
    .P_MAX_LEN    (MAX_LEN),
    .P_FIFO_DEPTH (2048),
    .P_GAP        (GAP)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_src_port       (src_port),
    .i_src_port_valid (src_v),
    .i_dst_port       (dst_port),
    .i_dst_port_valid (dst_v),
    .bus              (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  pay_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [15:0] mdl_src = 16'd8080;
  logic [15:0] mdl_dst = 16'd8080;
  logic [15:0] exp_len;
  bit          have_prev = 1'b0;
  bit          junk_en = 1'b0;
  int          frame_no = 0;

  // Length of the valid-low run preceding the most recent rising valid edge.
  int   low_run = 0;
  int   last_gap = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      low_run    <= 0;
      prev_valid <= 1'b0;
    end else begin
      prev_valid <= bus.o_ip_valid;
      if (bus.o_ip_valid) begin
        low_run <= 0;
        if (!prev_valid) last_gap <= low_run;
      end else begin
        low_run <= low_run + 1;
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame: header from the model ports, then the kept payload.
  task automatic build_exp();
    int keep;
    keep    = (pay_q.size() > MAX_LEN) ? MAX_LEN : pay_q.size();
    exp_len = 16'(keep + 8);
    exp_q.delete();
    exp_q.push_back(mdl_src[15:8]);
    exp_q.push_back(mdl_src[7:0]);
    exp_q.push_back(mdl_dst[15:8]);
    exp_q.push_back(mdl_dst[7:0]);
    exp_q.push_back(exp_len[15:8]);
    exp_q.push_back(exp_len[7:0]);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    for (int i = 0; i < keep; i++) exp_q.push_back(pay_q[i]);
  endtask

  task automatic fill_payload(input int n, input bit random_data);
    pay_q.delete();
    for (int i = 0; i < n; i++)
      pay_q.push_back(random_data ? 8'($urandom) : 8'(i));
  endtask

  task automatic set_ports(input logic [15:0] s, input logic [15:0] d);
    src_port = s;
    dst_port = d;
    src_v    = 1'b1;
    dst_v    = 1'b1;
    @(negedge clk);
    src_v    = 1'b0;
    dst_v    = 1'b0;
    mdl_src  = s;
    mdl_dst  = d;
  endtask

  // Bytes offered while the builder is emitting must be ignored.
  task automatic drive_junk();
    if (junk_en) begin
      bus.i_user_valid = 1'b1;
      bus.i_user_last  = 1'($urandom);
      bus.i_user_data  = 8'($urandom);
    end else begin
      bus.i_user_valid = 1'b0;
      bus.i_user_last  = 1'b0;
    end
  endtask

  task automatic send_frame(input bit gaps);
    int w = 0;
    while (!bus.o_user_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 32'(bus.o_user_ready), 32'd1);
    if (!bus.o_user_ready) return;
    for (int i = 0; i < pay_q.size(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        bus.i_user_valid = 1'b0;
        bus.i_user_last  = 1'b0;
        bus.i_user_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      bus.i_user_data  = pay_q[i];
      bus.i_user_valid = 1'b1;
      bus.i_user_last  = (i == pay_q.size() - 1);
      @(negedge clk);
      if (i == 0 && pay_q.size() > 1) chk("ready_load", 32'(bus.o_user_ready), 32'd0);
    end
    bus.i_user_valid = 1'b0;
    bus.i_user_last  = 1'b0;
  endtask

  // Called at the negedge right after the last payload byte was accepted.
  task automatic collect(input int chg_at);
    int          lat = 0;
    int          len_bad = 0;
    bit          broken = 1'b0;
    bit          tmo = 1'b0;
    logic [15:0] len0;
    logic [7:0]  type0;
    int          e0;
    got_q.delete();
    do begin
      drive_junk();
      @(negedge clk);
      lat++;
    end while (!bus.o_ip_valid && lat < 100);
    if (!bus.o_ip_valid) begin
      chk("first_valid_timeout", 32'd0, 32'd1);
      bus.i_user_valid = 1'b0;
      bus.i_user_last  = 1'b0;
      return;
    end
    // Acceptance cycle plus lat cycles: first header byte two cycles later.
    chk("latency", 32'(lat + 1), 32'd2);
    len0  = bus.o_ip_len;
    type0 = bus.o_ip_type;
    forever begin
      got_q.push_back(bus.o_ip_data);
      if (bus.o_ip_len !== len0) len_bad++;
      if (got_q.size() == chg_at) begin
        dst_port = 16'h1234;
        dst_v    = 1'b1;
      end
      if (bus.o_ip_last) break;
      if (got_q.size() >= 2000) begin
        tmo = 1'b1;
        break;
      end
      drive_junk();
      @(negedge clk);
      dst_v = 1'b0;
      if (!bus.o_ip_valid) begin
        broken = 1'b1;
        break;
      end
    end
    dst_v            = 1'b0;
    bus.i_user_valid = 1'b0;
    bus.i_user_last  = 1'b0;
    @(negedge clk);
    chk("post_valid", 32'(bus.o_ip_valid), 32'd0);
    chk("len", 32'(len0), 32'(exp_len));
    chk("len_stable", 32'(len_bad), 32'd0);
    chk("type", 32'(type0), 32'd17);
    chk("contiguous", 32'(broken), 32'd0);
    chk("frame_timeout", 32'(tmo), 32'd0);
    chk("nbytes", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      e0 = n_errors;
      chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      if (n_errors != e0) break;
    end
    if (have_prev) chk("gap_min", 32'(last_gap >= GAP), 32'd1);
    have_prev = 1'b1;
    frame_no++;
    $display("frame %0d: payload=%0d len=%0d bytes=%0d src=%04h dst=%04h gap=%0d",
             frame_no, pay_q.size(), len0, got_q.size(), mdl_src, mdl_dst, last_gap);
  endtask

  task automatic run_frame(input int n, input bit random_data, input bit gaps, input int chg_at);
    fill_payload(n, random_data);
    build_exp();
    send_frame(gaps);
    collect(chg_at);
    if (chg_at >= 0) mdl_dst = 16'h1234;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_valid"}, 32'(bus.o_ip_valid), 32'd0);
    chk({pfx, "_last"},  32'(bus.o_ip_last),  32'd0);
    chk({pfx, "_len"},   32'(bus.o_ip_len),   32'd0);
    chk({pfx, "_data"},  32'(bus.o_ip_data),  32'd0);
    chk({pfx, "_ready"}, 32'(bus.o_user_ready), 32'd1);
    chk({pfx, "_type"},  32'(bus.o_ip_type),  32'd17);
  endtask

  initial begin
    int seen;
    int w;
    rst              = 1'b1;
    src_port         = 16'h0;
    dst_port         = 16'h0;
    src_v            = 1'b0;
    dst_v            = 1'b0;
    bus.i_user_data  = 8'h00;
    bus.i_user_last  = 1'b0;
    bus.i_user_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // 18-byte incrementing payload with default ports.
    junk_en = 1'b0;
    run_frame(18, 1'b0, 1'b0, -1);
    // Single byte with valid and last together.
    junk_en = 1'b1;
    run_frame(1, 1'b1, 1'b0, -1);
    // Over-length payload is truncated to the maximum.
    junk_en = 1'b0;
    run_frame(1500, 1'b0, 1'b0, -1);
    // Back-to-back frames, second offered as soon as ready rises.
    run_frame(30, 1'b1, 1'b0, -1);
    run_frame(25, 1'b1, 1'b0, -1);
    // Destination port change during payload of A only affects B.
    junk_en = 1'b1;
    run_frame(40, 1'b1, 1'b0, 20);
    run_frame(10, 1'b1, 1'b1, -1);
    // Boundary lengths.
    junk_en = 1'b0;
    run_frame(MAX_LEN, 1'b1, 1'b0, -1);
    run_frame(MAX_LEN + 1, 1'b1, 1'b0, -1);
    // Randomized frames with gaps, junk and port changes.
    for (int k = 0; k < 12; k++) begin
      junk_en = 1'($urandom);
      if ($urandom_range(0, 2) == 0) set_ports(16'($urandom), 16'($urandom));
      run_frame($urandom_range(1, 120), 1'b1, 1'($urandom), -1);
    end

    // Reset in the middle of the payload, then a fresh 4-byte frame.
    junk_en = 1'b0;
    fill_payload(40, 1'b1);
    build_exp();
    send_frame(1'b0);
    seen = 0;
    w = 0;
    while (seen < 12 && w < 200) begin
      @(negedge clk);
      w++;
      if (bus.o_ip_valid) seen++;
    end
    chk("pre_rst_bytes", 32'(seen), 32'd12);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mdl_src   = 16'd8080;
    mdl_dst   = 16'd8080;
    have_prev = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.o_user_ready), 32'd1);
    run_frame(4, 1'b1, 1'b0, -1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
